// File: rtl/counter_controller.sv
// counter_controller
// ------------------
// Command-driven sequencer that owns an N-bit count register. Upstream logic
// hands it valid/ready commands to count up to a terminal value, count down
// from one, or free-run. The live count and busy/done/wrap status come out
// for use as a programmable timer or event counter.
//
// Build option: define COUNTER_CTRL_AUTO_RELOAD_EN to make the up and down
// modes reload their start value on each terminal hit instead of finishing.
// Without it, up/down runs are one-shot and pass through a single DONE cycle.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-low reset
//   cmd_valid  command present
//   cmd_ready  controller can accept a command (combinational)
//   cmd_op     00 COUNT_UP, 01 COUNT_DOWN, 10 FREE_RUN, 11 reserved
//   cmd_len    terminal value T, captured on accept
//   hold       freeze the count while high (RUN only)
//   stop       abort the current run
//   binary     current count value
//   busy       high while running
//   done       one-cycle pulse when a run reaches its end value
//   wrap       one-cycle pulse when FREE_RUN steps from all-ones to zero
//   cmd_err    one-cycle pulse after a reserved op is accepted

module counter_controller #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [N-1:0] cmd_len,
   input  logic         hold,
   input  logic         stop,
   output logic [N-1:0] binary,
   output logic         busy,
   output logic         done,
   output logic         wrap,
   output logic         cmd_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_UP   = 2'b00;
   localparam logic [1:0] OP_DOWN = 2'b01;
   localparam logic [1:0] OP_FREE = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   state_t       state;
   state_t       state_next;
   logic [N-1:0] binary_next;
   logic [N-1:0] len_q;
   logic [N-1:0] len_next;
   logic [1:0]   mode_q;
   logic [1:0]   mode_next;
   logic         done_next;
   logic         wrap_next;
   logic         err_next;
   logic         accept;
   logic [N-1:0] end_val;

   // Up mode finishes at T, down mode finishes at zero.
   assign end_val = (mode_q == OP_DOWN) ? '0 : len_q;

`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
   // Value reloaded on each terminal hit: zero going up, T going down.
   logic [N-1:0] start_val;
   assign start_val = (mode_q == OP_DOWN) ? len_q : '0;
`endif

   assign accept = cmd_valid & cmd_ready;

   // State register and all captured/pulse registers. Reset aborts any run
   // without producing a done pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_IDLE;
         binary  <= '0;
         len_q   <= '0;
         mode_q  <= OP_UP;
         done    <= 1'b0;
         wrap    <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         state   <= state_next;
         binary  <= binary_next;
         len_q   <= len_next;
         mode_q  <= mode_next;
         done    <= done_next;
         wrap    <= wrap_next;
         cmd_err <= err_next;
      end
   end

   // Next-state and next-datapath decisions. In RUN the priority is
   // stop > hold > terminal > step, so a hold on the terminal cycle simply
   // re-evaluates the terminal test one cycle later.
   always_comb begin
      state_next  = state;
      binary_next = binary;
      len_next    = len_q;
      mode_next   = mode_q;
      done_next   = 1'b0;
      wrap_next   = 1'b0;
      err_next    = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (cmd_op == OP_RSVD) begin
                  // Reserved op is consumed but leaves the count untouched.
                  err_next = 1'b1;
               end else begin
                  len_next    = cmd_len;
                  mode_next   = cmd_op;
                  state_next  = S_RUN;
                  binary_next = (cmd_op == OP_DOWN) ? cmd_len : '0;
               end
            end
         end
         S_RUN: begin
            if (stop) begin
               state_next = S_IDLE;
            end else if (hold) begin
               state_next = S_RUN;
            end else if (mode_q == OP_FREE) begin
               binary_next = binary + N'(1);
               wrap_next   = (binary == '1);
            end else if (binary == end_val) begin
               done_next = 1'b1;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
               binary_next = start_val;
`else
               state_next  = S_DONE;
`endif
            end else if (mode_q == OP_UP) begin
               binary_next = binary + N'(1);
            end else begin
               binary_next = binary - N'(1);
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Handshake and status decode. cmd_ready is forced low while reset is
   // asserted so nothing is accepted on the reset edge.
   always_comb begin
      cmd_ready = reset & (state == S_IDLE);
      busy      = (state == S_RUN);
   end

endmodule

// File: tb/tb_counter_controller.sv
// tb_counter_controller
// ---------------------
// Self-checking bench for counter_controller (N=4). A table of directed
// vectors covers reset, each op, hold/stop interplay and terminal corner
// cases; hand-written loops cover the long FREE_RUN wrap, reset during a run
// and the largest terminal value; a randomized phase compares every cycle
// against a reference model that tracks run progress arithmetically.

module tb_counter_controller;

   localparam int N = 4;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
   localparam bit RELOAD = 1'b1;
`else
   localparam bit RELOAD = 1'b0;
`endif

   logic         clk;
   logic         reset;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [N-1:0] cmd_len;
   logic         hold;
   logic         stop;
   logic [N-1:0] binary;
   logic         busy;
   logic         done;
   logic         wrap;
   logic         cmd_err;

   int total;
   int bad;

   typedef struct {
      string    name;
      bit       rst_n;
      bit       valid;
      bit [1:0] op;
      bit [3:0] len;
      bit       hold;
      bit       stop;
      bit [3:0] e_bin;
      bit       e_busy;
      bit       e_done;
      bit       e_wrap;
      bit       e_err;
      bit       e_ready;
   } vec_t;

   vec_t vecs[$];

   // Reference model state: phase 0 idle, 1 running, 2 finished.
   int m_phase;
   int m_prog;
   int m_T;
   int m_mode;
   int m_bin;
   bit m_done;
   bit m_wrap;
   bit m_err;

   counter_controller #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_len   (cmd_len),
      .hold      (hold),
      .stop      (stop),
      .binary    (binary),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap),
      .cmd_err   (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task addVec(input string name, input bit rst_n, input bit v, input bit [1:0] op,
               input bit [3:0] len, input bit h, input bit s, input bit [3:0] eb,
               input bit ebusy, input bit edone, input bit ewrap, input bit eerr,
               input bit eready);
      vec_t t;
      t.name = name; t.rst_n = rst_n; t.valid = v; t.op = op; t.len = len;
      t.hold = h; t.stop = s; t.e_bin = eb; t.e_busy = ebusy; t.e_done = edone;
      t.e_wrap = ewrap; t.e_err = eerr; t.e_ready = eready;
      vecs.push_back(t);
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task applyStimulus(input bit rst_n, input bit v, input bit [1:0] op,
                      input bit [3:0] len, input bit h, input bit s);
      reset     = rst_n;
      cmd_valid = v;
      cmd_op    = op;
      cmd_len   = len;
      hold      = h;
      stop      = s;
      @(posedge clk);
      #1;
   endtask

   task compareVal(input string tag, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, act, exp, $time);
      end
   endtask

   task checkOutput(input string name, input bit [3:0] eb, input bit ebusy,
                    input bit edone, input bit ewrap, input bit eerr, input bit eready);
      compareVal({name, ".binary"},    binary,              eb);
      compareVal({name, ".busy"},      {3'b000, busy},      {3'b000, ebusy});
      compareVal({name, ".done"},      {3'b000, done},      {3'b000, edone});
      compareVal({name, ".wrap"},      {3'b000, wrap},      {3'b000, ewrap});
      compareVal({name, ".cmd_err"},   {3'b000, cmd_err},   {3'b000, eerr});
      compareVal({name, ".cmd_ready"}, {3'b000, cmd_ready}, {3'b000, eready});
   endtask

   // Displayed count derived from how far the run has progressed.
   function automatic int shownValue();
      case (m_mode)
         1:       return m_T - m_prog;
         2:       return m_prog % 16;
         default: return m_prog;
      endcase
   endfunction

   function automatic void modelEdge(bit rst_n, bit v, bit [1:0] op, bit [3:0] len,
                                     bit h, bit s);
      m_done = 1'b0;
      m_wrap = 1'b0;
      m_err  = 1'b0;
      if (!rst_n) begin
         m_phase = 0; m_prog = 0; m_T = 0; m_mode = 0; m_bin = 0;
         return;
      end
      if (m_phase == 0) begin
         if (v) begin
            if (op == 2'b11) m_err = 1'b1;
            else begin
               m_mode = int'(op); m_T = int'(len); m_prog = 0; m_phase = 1;
               m_bin = shownValue();
            end
         end
      end else if (m_phase == 1) begin
         if (s) m_phase = 0;
         else if (!h) begin
            if (m_mode == 2) begin
               m_prog++;
               m_wrap = ((m_prog % 16) == 0);
            end else if (m_prog == m_T) begin
               m_done = 1'b1;
               if (RELOAD) m_prog = 0;
               else m_phase = 2;
            end else begin
               m_prog++;
            end
            m_bin = shownValue();
         end
      end else begin
         m_phase = 0;
      end
   endfunction

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = '0;
      hold = 1'b0; stop = 1'b0;

      // Directed vector table
      addVec("reset_low",  0,0,0,0,0,0, 0,0,0,0,0,0);
      addVec("reset_low2", 0,0,0,0,0,0, 0,0,0,0,0,0);
      addVec("idle",       1,0,0,0,0,0, 0,0,0,0,0,1);
      addVec("rsv_accept", 1,1,3,9,0,0, 0,0,0,0,1,1);
      addVec("rsv_clear",  1,0,0,0,0,0, 0,0,0,0,0,1);
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
      addVec("ar_accept",  1,1,0,2,0,0, 0,1,0,0,0,0);
      addVec("ar_step",    1,0,0,0,0,0, 1,1,0,0,0,0);
      addVec("ar_step",    1,0,0,0,0,0, 2,1,0,0,0,0);
      addVec("ar_reload",  1,0,0,0,0,0, 0,1,1,0,0,0);
      addVec("ar_step",    1,1,1,9,0,0, 1,1,0,0,0,0);
      addVec("ar_step",    1,0,0,0,0,0, 2,1,0,0,0,0);
      addVec("ar_reload",  1,0,0,0,0,0, 0,1,1,0,0,0);
      addVec("ar_step",    1,0,0,0,0,0, 1,1,0,0,0,0);
      addVec("ar_stop",    1,0,0,0,0,1, 1,0,0,0,0,1);
      addVec("ard_accept", 1,1,1,1,0,0, 1,1,0,0,0,0);
      addVec("ard_step",   1,0,0,0,0,0, 0,1,0,0,0,0);
      addVec("ard_hold",   1,0,0,0,1,0, 0,1,0,0,0,0);
      addVec("ard_reload", 1,0,0,0,0,0, 1,1,1,0,0,0);
      addVec("ard_stop",   1,0,0,0,0,1, 1,0,0,0,0,1);
`else
      addVec("up_accept",  1,1,0,5,0,0, 0,1,0,0,0,0);
      for (int i = 1; i <= 5; i++)
         addVec("up_step", 1,1,1,9,0,0, 4'(i),1,0,0,0,0);
      addVec("up_done",    1,0,0,0,0,0, 5,0,1,0,0,0);
      addVec("up_ready",   1,0,0,0,0,0, 5,0,0,0,0,1);
      addVec("dn_accept",  1,1,1,3,0,0, 3,1,0,0,0,0);
      addVec("dn_step",    1,0,0,0,0,0, 2,1,0,0,0,0);
      addVec("dn_hold",    1,0,0,0,1,0, 2,1,0,0,0,0);
      addVec("dn_hold",    1,0,0,0,1,0, 2,1,0,0,0,0);
      addVec("dn_step",    1,0,0,0,0,0, 1,1,0,0,0,0);
      addVec("dn_step",    1,0,0,0,0,0, 0,1,0,0,0,0);
      addVec("dn_done",    1,0,0,0,0,0, 0,0,1,0,0,0);
      addVec("dn_ready",   1,0,0,0,0,0, 0,0,0,0,0,1);
      addVec("dn0_accept", 1,1,1,0,0,0, 0,1,0,0,0,0);
      addVec("dn0_done",   1,0,0,0,0,0, 0,0,1,0,0,0);
      addVec("dn0_ready",  1,0,0,0,0,0, 0,0,0,0,0,1);
      addVec("up0_accept", 1,1,0,0,0,0, 0,1,0,0,0,0);
      addVec("up0_done",   1,0,0,0,0,0, 0,0,1,0,0,0);
      addVec("up0_ready",  1,0,0,0,0,0, 0,0,0,0,0,1);
      addVec("ht_accept",  1,1,0,1,0,0, 0,1,0,0,0,0);
      addVec("ht_step",    1,0,0,0,0,0, 1,1,0,0,0,0);
      addVec("ht_hold",    1,0,0,0,1,0, 1,1,0,0,0,0);
      addVec("ht_done",    1,0,0,0,0,0, 1,0,1,0,0,0);
      addVec("ht_ready",   1,0,0,0,0,0, 1,0,0,0,0,1);
`endif
      addVec("st_accept",  1,1,0,2,0,0, 0,1,0,0,0,0);
      addVec("st_step",    1,0,0,0,0,0, 1,1,0,0,0,0);
      addVec("st_step",    1,0,0,0,0,0, 2,1,0,0,0,0);
      addVec("st_stop",    1,0,0,0,0,1, 2,0,0,0,0,1);
      addVec("st_idle",    1,0,0,0,0,0, 2,0,0,0,0,1);
      addVec("ign_accept", 1,1,2,0,1,1, 0,1,0,0,0,0);
      addVec("ign_stop",   1,0,0,0,0,1, 0,0,0,0,0,1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst_n, vecs[i].valid, vecs[i].op, vecs[i].len,
                       vecs[i].hold, vecs[i].stop);
         checkOutput(vecs[i].name, vecs[i].e_bin, vecs[i].e_busy, vecs[i].e_done,
                     vecs[i].e_wrap, vecs[i].e_err, vecs[i].e_ready);
      end

      // FREE_RUN: two wraps 16 cycles apart, then stop at 7
      applyStimulus(1,1,2'b10,4'd3,0,0);
      checkOutput("free_accept", 4'd0,1,0,0,0,0);
      for (int w = 0; w < 2; w++) begin
         for (int i = 1; i <= 15; i++) begin
            applyStimulus(1,0,2'b00,4'd0,0,0);
            checkOutput("free_step", 4'(i),1,0,0,0,0);
         end
         applyStimulus(1,0,2'b00,4'd0,0,0);
         checkOutput("free_wrap", 4'd0,1,0,1,0,0);
      end
      for (int i = 1; i <= 7; i++) begin
         applyStimulus(1,0,2'b00,4'd0,0,0);
         checkOutput("free_step2", 4'(i),1,0,0,0,0);
      end
      applyStimulus(1,0,2'b00,4'd0,0,1);
      checkOutput("free_stop", 4'd7,0,0,0,0,1);
      applyStimulus(1,0,2'b00,4'd0,0,0);
      checkOutput("free_after", 4'd7,0,0,0,0,1);

      // Reset held low for two edges in the middle of a FREE_RUN
      applyStimulus(1,1,2'b10,4'd0,0,0);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1,0,2'b00,4'd0,0,0);
         checkOutput("rst_run", 4'(i),1,0,0,0,0);
      end
      reset = 1'b0;
      #1;
      compareVal("rst_ready_comb", {3'b000, cmd_ready}, 4'd0);
      applyStimulus(0,1,2'b00,4'd4,0,0);
      checkOutput("rst_edge1", 4'd0,0,0,0,0,0);
      applyStimulus(0,1,2'b00,4'd4,0,0);
      checkOutput("rst_edge2", 4'd0,0,0,0,0,0);
      applyStimulus(1,0,2'b00,4'd0,0,0);
      checkOutput("rst_release", 4'd0,0,0,0,0,1);

      // Largest terminal value counts all the way without overflowing
      applyStimulus(1,1,2'b00,4'd15,0,0);
      checkOutput("max_accept", 4'd0,1,0,0,0,0);
      for (int i = 1; i <= 15; i++) begin
         applyStimulus(1,0,2'b00,4'd0,0,0);
         checkOutput("max_step", 4'(i),1,0,0,0,0);
      end
      applyStimulus(1,0,2'b00,4'd0,0,0);
      checkOutput("max_term", RELOAD ? 4'd0 : 4'd15, RELOAD,1,0,0,0);
      applyStimulus(1,0,2'b00,4'd0,0,RELOAD);
      checkOutput("max_end", RELOAD ? 4'd0 : 4'd15,0,0,0,0,1);

      // Randomized phase against the reference model
      modelEdge(0,0,2'b00,4'd0,0,0);
      applyStimulus(0,0,2'b00,4'd0,0,0);
      checkOutput("rand_reset", 4'd0,0,0,0,0,0);
      for (int c = 0; c < 3000; c++) begin
         bit       r_rst;
         bit       r_v;
         bit [1:0] r_op;
         bit [3:0] r_len;
         bit       r_h;
         bit       r_s;
         r_rst = ($urandom_range(0, 149) != 0);
         r_v   = ($urandom_range(0, 2) == 0);
         r_op  = 2'($urandom_range(0, 3));
         r_len = 4'($urandom_range(0, 15));
         r_h   = ($urandom_range(0, 3) == 0);
         r_s   = ($urandom_range(0, 39) == 0);
         modelEdge(r_rst, r_v, r_op, r_len, r_h, r_s);
         applyStimulus(r_rst, r_v, r_op, r_len, r_h, r_s);
         checkOutput("rand", 4'(m_bin), (m_phase == 1), m_done, m_wrap, m_err,
                     r_rst && (m_phase == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_controller.md
Name: counter_controller

Overview:
- Command-driven sequencer for the team's N-bit binary counter datapath; owns the count register and decides when it loads, steps, holds and stops.
- Upstream logic issues valid/ready commands: count up to a terminal value, count down from one, or free-run.
- Outputs the live count (`binary`) plus busy, done and wrap status, for use as a programmable timer or event counter.

Parameters:
- N, 4, count width in bits; `binary` and `cmd_len` are N bits wide.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  00 COUNT_UP, 01 COUNT_DOWN, 10 FREE_RUN, 11 reserved.
- cmd_len  input  N  terminal value T, captured on accept.
- hold  input  1  freeze count while high (RUN only).
- stop  input  1  abort the current run.
- binary  output  N  current count value.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a run completes.
- wrap  output  1  one-cycle pulse on FREE_RUN wrap from 2^N-1 to 0.
- cmd_err  output  1  one-cycle pulse when a reserved op is accepted.

Behaviour:
- Reset: reset==0 at a rising edge sets state=IDLE, binary=0, busy=0, done=0, wrap=0, cmd_err=0, and clears the captured T and op. A run in progress is aborted with no done pulse.
- cmd_ready = reset & (state==IDLE), combinational. It is 0 while reset is low.
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_valid & cmd_ready at an edge means the command is accepted.
  - op 00: binary<=0, go to RUN. Start value 0, end value T.
  - op 01: binary<=T, go to RUN. Start value T, end value 0.
  - op 10: binary<=0, go to RUN, no end value.
  - op 11: stay in IDLE, pulse cmd_err next cycle, binary unchanged.
  - hold and stop are ignored in IDLE.
- RUN: priority at each edge is stop > hold > terminal > step.
  - stop=1: go to IDLE, binary keeps its value, no done pulse.
  - hold=1: no change.
  - binary==end (up/down modes): go to DONE, done=1 for that cycle, binary holds the end value.
  - Otherwise step: up mode binary+1, down mode binary-1.
  - FREE_RUN: binary+1 modulo 2^N. Stepping from 2^N-1 to 0 pulses wrap for one cycle. FREE_RUN exits only on stop.
- DONE: one cycle, then IDLE. done is high only during the DONE cycle. A new command can be accepted on the edge after DONE.
- Latency, no hold:
  - Accept at edge k puts binary=start after edge k.
  - done is high after edge k+T+1.
  - cmd_ready is high again after edge k+T+2.
  - Each hold cycle adds one cycle.
- Boundary cases:
  - T=0 in up or down mode: done after edge k+1.
  - T=2^N-1 is legal; counting never overflows in up or down mode.
  - stop and terminal in the same cycle: stop wins, no done.
  - hold and terminal in the same cycle: hold wins, evaluated again next cycle.
  - busy = (state==RUN), registered.

Optional Feature:
- Macro: COUNTER_CTRL_AUTO_RELOAD_EN.
- Defined: up and down modes never enter DONE. On reaching the end value with hold=0, binary reloads the start value on the next edge. done pulses for one cycle on each terminal hit while state stays RUN. stop is the only exit, and cmd_ready stays 0 until then.
- Undefined: one-shot behaviour as described in Behaviour.

Test Plan:
- Reset: hold reset=0 for 2 edges mid FREE_RUN -> binary=0, busy=0, cmd_ready=0 while low; cmd_ready=1 on the first edge after reset=1.
- COUNT_UP, N=4, T=5: binary 0,1,2,3,4,5; done pulse exactly once 6 cycles after accept; cmd_ready=1 the following cycle.
- COUNT_DOWN, T=3, hold high for 2 cycles at binary=2: sequence 3,2,2,2,1,0; done 6 cycles after accept; T=0 case gives done after 1 cycle.
- FREE_RUN, N=4: wrap pulses when binary goes 15->0, repeated every 16 cycles; stop at binary=7 -> IDLE with binary=7, no done.
- Reserved op 11 with cmd_valid=1 -> accepted, cmd_err pulse 1 cycle, state stays IDLE; stop asserted at the terminal cycle of COUNT_UP T=2 -> no done.
- COUNTER_CTRL_AUTO_RELOAD_EN defined, COUNT_UP T=2: sequence 0,1,2,0,1,2; done pulse every 3 cycles; busy stays 1 until stop.
